kernel_window_ctrl: RTL and testbench
=====================================

KERNEL_WINDOW_CTRL -- requirements
Module: kernel_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, pixels per image row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 128, rows per frame.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 3, window columns.
REQ-004 SHALL have parameter BLOCK_HEIGHT, default 3, window rows.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-008 SHALL have port s_valid  input  1  upstream pixel valid.
REQ-009 SHALL have port s_ready  output  1  pixel accepted when s_valid && s_ready; also drives the kernel shift enable.
REQ-010 SHALL have port m_ready  input  1  downstream ready for a window.
REQ-011 SHALL have port m_valid  output  1  kernel window complete and inside the image.
REQ-012 SHALL have port win_col  output  clog2(IMG_WIDTH)  column of the window's right-most pixel.
REQ-013 SHALL have port win_row  output  clog2(IMG_HEIGHT)  row of the window's bottom pixel.
REQ-014 SHALL have port busy  output  1  frame in progress.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last window handshakes.

Function
REQ-016 SHALL implement FSM IDLE -> ACTIVE (start) -> DRAIN (last pixel accepted) -> DONE (m_valid low, or m_valid && m_ready) -> IDLE.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL drive s_ready = (state==ACTIVE) && (!m_valid || m_ready); the controller is a one-entry pipeline stage.
REQ-019 SHALL, on each accept, advance col 0..IMG_WIDTH-1, wrapping to 0 and incrementing row; col and row clear on entering ACTIVE.
REQ-020 SHALL register m_valid one cycle after an accept when col>=BLOCK_WIDTH-1 && row>=BLOCK_HEIGHT-1, latching win_col/win_row = col/row.
REQ-021 SHALL hold m_valid, win_col and win_row stable until m_ready; m_valid clears on handshake unless a new qualifying accept occurs in the same cycle.
REQ-022 SHALL, for an accept outside the window region (left-edge or top-row fill), produce no m_valid.
REQ-023 SHALL enter DRAIN on the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) and accept no further pixels.
REQ-024 SHALL pulse frame_done exactly once per frame, in the DONE cycle.
REQ-025 SHALL drive busy high in ACTIVE, DRAIN and DONE.
REQ-026 SHALL emit (IMG_WIDTH-BLOCK_WIDTH+1)*(IMG_HEIGHT-BLOCK_HEIGHT+1) windows per frame.

Reset
REQ-027 SHALL, on rst low, immediately force state=IDLE, col=row=0, s_ready=0, m_valid=0, win_col=win_row=0, busy=0, frame_done=0, and stall_cnt=0 where present.
REQ-028 SHALL discard any pending window when reset occurs mid-frame; the first frame after reset requires start.

Configuration
REQ-029 SHALL, when KERNEL_WINDOW_CTRL_STALL_CNT_EN is defined, add output stall_cnt [31:0], counting ACTIVE cycles with s_valid && !s_ready, cleared on start and saturating at all-ones.
REQ-030 SHALL, when KERNEL_WINDOW_CTRL_STALL_CNT_EN is not defined, omit the stall_cnt port and logic.

Structure
REQ-031 SHALL take the FSM state enum and the shared IMG_WIDTH/IMG_HEIGHT constants from the HOG package.
REQ-032 SHALL contain one sub-module, pos_counter, a wrapping column/row counter with enable and clear.

Verification
REQ-033 SHALL test: 8x4 image, 3x3 window, s_valid and m_ready held high -> 6*2=12 m_valid handshakes; first at (col2,row2), last at (col7,row3); frame_done one cycle after the last handshake.
REQ-034 SHALL test: m_ready low for 5 cycles while m_valid is high -> s_ready=0, win_col/win_row unchanged, no pixel lost.
REQ-035 SHALL test: start asserted while ACTIVE -> no effect; counters continue.
REQ-036 SHALL test: rst low mid-row (col=4,row=2) -> all outputs 0 the same cycle; next frame begins at (0,0) after start.
REQ-037 SHALL test: s_valid toggling every other cycle -> window count still 12 and coordinates monotonic.
REQ-038 SHALL test, with STALL_CNT_EN defined: 5-cycle m_ready stall with s_valid high -> stall_cnt=5.

Source files
------------

// File: rtl/kernel_window_ctrl_pkg.sv
// Shared constants for the kernel window controller: default image geometry,
// FSM state encodings and a width helper for coordinate buses.
package kernel_window_ctrl_pkg;

    localparam int DEF_IMG_WIDTH  = 64;
    localparam int DEF_IMG_HEIGHT = 128;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kernel_window_ctrl_pos_counter.sv
// pos_counter: raster-order column/row position counter. Column wraps at
// WIDTH-1 and bumps the row; row wraps at HEIGHT-1. 'last' flags the final
// pixel position of the frame.
module pos_counter
    import kernel_window_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_IMG_WIDTH,
    parameter int HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    output logic [idx_w(WIDTH)-1:0]   col,
    output logic [idx_w(HEIGHT)-1:0]  row,
    output logic                      last
);

    localparam int CW = idx_w(WIDTH);
    localparam int RW = idx_w(HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    // Advance position on enable; clear has priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/kernel_window_ctrl.sv
// kernel_window_ctrl: walks a frame in raster order, accepting one pixel per
// handshake, and raises a window event whenever the accepted pixel completes a
// BLOCK_WIDTH x BLOCK_HEIGHT kernel fully inside the image.
// Optional build macro: KERNEL_WINDOW_CTRL_STALL_CNT_EN adds stall_cnt.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The window output is a one-entry stage: m_valid, win_col and
// win_row hold until m_ready, and s_ready only rises when that stage is empty
// or emptying this cycle, so no window is ever overwritten.
module kernel_window_ctrl
    import kernel_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int BLOCK_WIDTH  = 3,
    parameter int BLOCK_HEIGHT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          m_ready,
    output logic                          m_valid,
    output logic [idx_w(IMG_WIDTH)-1:0]   win_col,
    output logic [idx_w(IMG_HEIGHT)-1:0]  win_row,
    output logic                          busy,
    output logic                          frame_done,
`ifdef KERNEL_WINDOW_CTRL_STALL_CNT_EN
    output logic [31:0]                   stall_cnt,
`endif
    output logic [1:0]                    state_dbg
);

    localparam int CW = idx_w(IMG_WIDTH);
    localparam int RW = idx_w(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_MIN = CW'(BLOCK_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(BLOCK_HEIGHT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            last_pix;
    logic            accept;
    logic            in_win;
    logic            frame_start;

    assign frame_start = (state == ST_IDLE) && start;
    assign s_ready     = (state == ST_ACTIVE) && (!m_valid || m_ready);
    assign accept      = s_valid && s_ready;
    assign in_win      = (col >= COL_MIN) && (row >= ROW_MIN);
    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_DONE);
    assign state_dbg   = state;

    pos_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start),
        .en   (accept),
        .col  (col),
        .row  (row),
        .last (last_pix)
    );

    // Next-state decode for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (accept && last_pix) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!m_valid || m_ready) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Window output stage: load on a qualifying accept, drain on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            win_col <= '0;
            win_row <= '0;
        end else if (accept && in_win) begin
            m_valid <= 1'b1;
            win_col <= col;
            win_row <= row;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef KERNEL_WINDOW_CTRL_STALL_CNT_EN
    // Count ACTIVE cycles where upstream offered a pixel but was held off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (frame_start) begin
            stall_cnt <= '0;
        end else if ((state == ST_ACTIVE) && s_valid && !s_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_window_ctrl.sv
// Bench for kernel_window_ctrl on an 8x4 image with a 3x3 kernel.
module tb_kernel_window_ctrl;

    localparam int IW = 8;
    localparam int IH = 4;
    localparam int CW = 3;
    localparam int RW = 2;
    localparam int WW = CW + RW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          busy;
    logic          frame_done;
    logic [1:0]    state_dbg;
`ifdef KERNEL_WINDOW_CTRL_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    kernel_window_ctrl #(
        .IMG_WIDTH    (IW),
        .IMG_HEIGHT   (IH),
        .BLOCK_WIDTH  (3),
        .BLOCK_HEIGHT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .busy       (busy),
        .frame_done (frame_done),
`ifdef KERNEL_WINDOW_CTRL_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected windows as {row, col}, in emission order.
    logic [WW-1:0] exp_q[$];
    bit mon_en = 1'b0;
    int n_win = 0;
    int n_fd = 0;
    int last_hs_cyc = 0;
    int fd_cyc = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_valid && m_ready) begin
                n_win++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_window", {27'd0, win_row, win_col}, 32'hffff_ffff);
                end else begin
                    chk("window_coord", {27'd0, win_row, win_col}, {27'd0, exp_q.pop_front()});
                end
            end
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
            end
        end
    end

    typedef struct {
        logic       start;
        logic       sv;
        logic       mr;
        logic [8:0] exp_out;  // {s_ready, m_valid, win_col, win_row, busy, frame_done}
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic st, input logic sv, input logic mr,
                                input logic sr, input logic mv, input int wc,
                                input int wr, input logic bz, input logic fd);
        vec_t v;
        logic [CW-1:0] c;
        logic [RW-1:0] r;
        c = CW'(wc);
        r = RW'(wr);
        v.start = st;
        v.sv = sv;
        v.mr = mr;
        v.exp_out = {sr, mv, c, r, bz, fd};
        return v;
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_expected();
        logic [WW-1:0] w;
        exp_q.delete();
        for (int r = 2; r < IH; r++) begin
            for (int c = 2; c < IW; c++) begin
                w = WW'(r * (1 << CW) + c);
                exp_q.push_back(w);
            end
        end
    endtask

    // Run one whole frame from IDLE, with optional s_valid toggling, a single
    // 5-cycle m_ready stall on the first window, and a stray mid-frame start.
    task automatic run_frame(input string tag, input bit toggle_sv, input bit do_stall, input bit mid_start);
        int c;
        bit stalled;
        logic [WW-1:0] w;
        load_expected();
        n_win = 0;
        n_fd = 0;
        mon_en = 1'b1;
        start = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 0;
        stalled = 1'b0;
        while (n_fd == 0 && c < 400) begin
            s_valid = toggle_sv ? c[0] : 1'b1;
            start = mid_start && (c == 10);
            if (do_stall && !stalled && m_valid) begin
                m_ready = 1'b0;
                w = {win_row, win_col};
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    #1;
                    chk({tag, "_stall_hold"}, {29'd0, s_ready, m_valid, busy}, {29'd0, 3'b011});
                    chk({tag, "_stall_win"}, {27'd0, win_row, win_col}, {27'd0, w});
                end
                m_ready = 1'b1;
                stalled = 1'b1;
                c += 5;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        chk({tag, "_timeout"}, {31'd0, (c >= 400)}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk({tag, "_win_count"}, n_win, 32'd12);
        chk({tag, "_queue_left"}, exp_q.size(), 32'd0);
        chk({tag, "_done_pulses"}, n_fd, 32'd1);
        chk({tag, "_done_delay"}, fd_cyc - last_hs_cyc, 32'd1);
        chk({tag, "_idle_after"}, {29'd0, busy, s_ready, m_valid}, 32'd0);
        if (do_stall) chk({tag, "_stall_seen"}, {31'd0, stalled}, 32'd1);
        s_valid = 1'b0;
    endtask

    initial begin
        // Reset state while rst is held low.
        #2;
        chk("reset_outputs", {22'd0, s_ready, m_valid, win_col, win_row, busy, frame_done},
            32'd0);
        chk("reset_state", {30'd0, state_dbg}, 32'd0);
        apply_reset();
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("no_start_idle", {30'd0, s_ready, busy}, 32'd0);
        s_valid = 1'b0;

        // Table: frame start, top/left fill, first windows, stalls, ignored start.
        vecs[0] = mk(1, 0, 1, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 18; i++) vecs[i] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0);
        vecs[19] = mk(0, 1, 0, 0, 1, 2, 2, 1, 0);
        vecs[20] = mk(0, 1, 0, 0, 1, 2, 2, 1, 0);
        vecs[21] = mk(0, 1, 1, 1, 1, 3, 2, 1, 0);
        vecs[22] = mk(0, 0, 1, 1, 0, 3, 2, 1, 0);
        vecs[23] = mk(0, 0, 0, 1, 0, 3, 2, 1, 0);
        vecs[24] = mk(0, 1, 0, 0, 1, 4, 2, 1, 0);
        vecs[25] = mk(1, 0, 1, 1, 0, 4, 2, 1, 0);
        for (int i = 0; i < 26; i++) begin
            start = vecs[i].start;
            s_valid = vecs[i].sv;
            m_ready = vecs[i].mr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {23'd0, s_ready, m_valid, win_col, win_row, busy, frame_done},
                {23'd0, vecs[i].exp_out});
        end
        chk("vec_state_active", {30'd0, state_dbg}, 32'd1);

        // Full frame, both sides always ready.
        apply_reset();
        run_frame("full", 1'b0, 1'b0, 1'b0);

        // Downstream stall of five cycles on the first window.
        run_frame("stall", 1'b0, 1'b1, 1'b0);
`ifdef KERNEL_WINDOW_CTRL_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd5);
`endif

        // Bursty upstream plus a start pulse during ACTIVE.
        run_frame("toggle", 1'b1, 1'b0, 1'b1);
`ifdef KERNEL_WINDOW_CTRL_STALL_CNT_EN
        chk("stall_cnt_zero", stall_cnt, 32'd0);
`endif

        // Reset mid-row at (col 4, row 2) with a window pending.
        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("pre_reset_window", {26'd0, m_valid, win_row, win_col}, {26'd0, 1'b1, 2'd2, 3'd3});
        rst = 1'b0;
        #1;
        chk("async_reset_outputs",
            {20'd0, s_ready, m_valid, win_col, win_row, busy, frame_done, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_needs_start", {29'd0, s_ready, busy, m_valid}, 32'd0);
        s_valid = 1'b0;
        run_frame("after_reset", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
